mt_info_dispatcher: RTL
=======================

# mt_info_dispatcher

Downstream consumer of the MT info buffer. Pops one 32-bit MT info entry at a time, decodes its base address, beat count and tag, and splits the transfer into AXI-style read-address bursts of at most `MAX_BURST` beats. It sits between the MT info buffer and the near-memory read engine's AR channel.

## Interface
Parameters:
- `MAX_BURST`, default 16: maximum beats per issued burst; power of two, 1..256.
- `BEAT_BYTES`, default 8: bytes per beat; the address advances by `beats*BEAT_BYTES` per burst.

Ports:
- `clk` in 1: single clock; all logic on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `info_in` in 32: head entry of the MT info buffer (first-word-fall-through).
  - [31:12] = base address bits [31:12]; low address bits are 0.
  - [11:4] = beat count.
  - [3:0] = tag.
- `info_empty` in 1: buffer empty; `info_in` is valid only when low.
- `info_re` out 1: one-cycle pop pulse to the buffer.
- `ar_valid` out 1: burst request valid.
- `ar_ready` in 1: downstream accepts the request.
- `ar_addr` out 32: burst byte address.
- `ar_len` out 8: beats minus 1.
- `ar_id` out 4: tag of the entry.
- `busy` out 1: high whenever the state is not IDLE.
- `done` out 1: one-cycle pulse when an entry's last burst is accepted.
- `drop_cnt` out 8: count of zero-length entries dropped; saturates at 255.

## Operation
- FSM states: IDLE, ISSUE.
- IDLE:
  - If `info_empty`=0: assert `info_re` for one cycle and latch `info_in` in the same cycle.
  - If the beat count is 0: `drop_cnt` increments (saturating) and the FSM stays in IDLE. Back-to-back drops are possible, one per cycle.
  - Otherwise: load `addr`={info[31:12],12'h000}, `remaining`=beat count, `tag`=info[3:0], and go to ISSUE.
- ISSUE:
  - `ar_valid`=1, `ar_addr`=addr, `ar_len`=min(remaining,MAX_BURST)-1, `ar_id`=tag.
  - All AR outputs are held stable while `ar_valid`=1 and `ar_ready`=0.
  - On `ar_valid & ar_ready`: `remaining` -= burst beats; `addr` += burst beats*BEAT_BYTES.
  - If `remaining` becomes 0: pulse `done`, deassert `ar_valid`, and go to IDLE. Otherwise stay in ISSUE with the next burst's values on the following cycle.
- `info_re` is never asserted in ISSUE, so the buffer is not popped while a transfer is in flight.
- Width rules:
  - `remaining` is 8 bits.
  - The address adder is 32 bits and wraps modulo 2^32 with no error.
  - The maximum transfer of 255*8 bytes never crosses a 4 KB page.

## Timing
- Reset values: `info_re`=0, `ar_valid`=0, `ar_addr`=0, `ar_len`=0, `ar_id`=0, `busy`=0, `done`=0, `drop_cnt`=0. The state is IDLE.
- All outputs are registered except `info_re`, which is decoded from state and `info_empty` in the same cycle.
- Pop to first `ar_valid`: 1 cycle. The pop is at edge N and `ar_valid` is high after edge N+1.
- Consecutive bursts of one entry issue every cycle while `ar_ready`=1.
- After `done` there is one IDLE cycle before the next pop, so the minimum gap between entries is 1 cycle.
- `done` asserts in the cycle after the final handshake, concurrent with `ar_valid` falling.
- `rst` during ISSUE: the transfer is abandoned and `ar_valid` drops on the next edge. The popped entry is lost, with no replay.
- `info_empty` rising in the same cycle as IDLE sampling: no pop.

## Structure
- Shared package `mt_info_pkg` holds:
  - field position constants: `MT_ADDR_MSB`/`LSB`, `MT_LEN_MSB`/`LSB`, `MT_TAG_MSB`/`LSB`;
  - the state enum `mt_disp_state_t` {IDLE, ISSUE};
  - the default `BEAT_BYTES`.
- The MT info buffer imports the same field constants.
- One sub-module is natural: `mt_burst_calc`. It is combinational: given `remaining`, `addr` and `MAX_BURST`, it returns the burst beats, `ar_len`, next `addr` and next `remaining`.

## Test plan
- **Single entry**, `info_in`=0x12345_28_3 (addr 0x12345000, 40 beats, tag 3), `ar_ready` held 1 → bursts at 0x12345000/len 15, 0x12345080/len 15, 0x12345100/len 7, all with id 3. `done` pulses once; `info_re` pulses exactly once.
- **Backpressure**: same entry with `ar_ready` low for 5 cycles on the 2nd burst → 0x12345080/len 15 held stable throughout; no `info_re` while busy.
- **Zero-length drops**: three entries with beat count 0, then one with 1 beat → `drop_cnt`=3, `info_re` high for 4 consecutive cycles, then one burst with len 0.
- **Saturation**: 300 zero-length entries → `drop_cnt`=255.
- **Address wrap**: `info_in`=0xFFFFF_20_1 (32 beats) → bursts at 0xFFFFF000 then 0xFFFFF080, both len 15.
- **Reset mid-operation**: `rst` asserted during the 2nd burst of a 40-beat entry → the next cycle shows all outputs 0 and the state IDLE. A following entry is processed normally.

Source files
------------

// File: rtl/mt_info_pkg.sv
// Shared definitions for the MT info buffer and its dispatcher.
// Holds the entry field layout, datapath widths and the dispatcher state type.
package mt_info_pkg;

    // Field layout of one 32-bit MT info entry
    localparam int unsigned MT_ADDR_MSB = 31;
    localparam int unsigned MT_ADDR_LSB = 12;
    localparam int unsigned MT_LEN_MSB  = 11;
    localparam int unsigned MT_LEN_LSB  = 4;
    localparam int unsigned MT_TAG_MSB  = 3;
    localparam int unsigned MT_TAG_LSB  = 0;

    localparam int unsigned MT_INFO_W  = 32;
    localparam int unsigned MT_ADDR_W  = 32;
    localparam int unsigned MT_LEN_W   = MT_LEN_MSB - MT_LEN_LSB + 1;
    localparam int unsigned MT_TAG_W   = MT_TAG_MSB - MT_TAG_LSB + 1;
    localparam int unsigned MT_BEATS_W = MT_LEN_W + 1;

    localparam int unsigned MT_DEFAULT_BEAT_BYTES = 8;

    typedef enum logic {
        IDLE  = 1'b0,
        ISSUE = 1'b1
    } mt_disp_state_t;

endpackage

// File: rtl/mt_burst_calc.sv
// Combinational burst splitter: size of the next burst and the state left after it.
// A burst is min(remaining, MAX_BURST) beats; the address wraps modulo 2^32.
module mt_burst_calc
    import mt_info_pkg::*;
#(
    parameter int unsigned MAX_BURST  = 16,
    parameter int unsigned BEAT_BYTES = MT_DEFAULT_BEAT_BYTES
) (
    input  logic [MT_LEN_W-1:0]   remaining,
    input  logic [MT_ADDR_W-1:0]  addr,
    output logic [MT_BEATS_W-1:0] beats,
    output logic [MT_LEN_W-1:0]   len,
    output logic [MT_ADDR_W-1:0]  next_addr,
    output logic [MT_LEN_W-1:0]   next_remaining
);

    // Nine bits so MAX_BURST=256 is representable
    localparam logic [MT_BEATS_W-1:0] MAX_BEATS = MT_BEATS_W'(MAX_BURST);

    logic [MT_BEATS_W-1:0] rem_ext;

    always_comb begin
        rem_ext        = MT_BEATS_W'(remaining);
        beats          = (rem_ext > MAX_BEATS) ? MAX_BEATS : rem_ext;
        len            = MT_LEN_W'(beats - MT_BEATS_W'(1));
        next_addr      = addr + (MT_ADDR_W'(beats) * MT_ADDR_W'(BEAT_BYTES));
        next_remaining = MT_LEN_W'(rem_ext - beats);
    end

endmodule

// File: rtl/mt_info_dispatcher.sv
// Pops MT info entries and splits each into AR bursts of at most MAX_BURST beats.
// Zero-length entries are dropped and counted; the buffer is never popped mid-transfer.
module mt_info_dispatcher
    import mt_info_pkg::*;
#(
    parameter int unsigned MAX_BURST  = 16,
    parameter int unsigned BEAT_BYTES = MT_DEFAULT_BEAT_BYTES
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [MT_INFO_W-1:0] info_in,
    input  logic                 info_empty,
    output logic                 info_re,
    output logic                 ar_valid,
    input  logic                 ar_ready,
    output logic [MT_ADDR_W-1:0] ar_addr,
    output logic [MT_LEN_W-1:0]  ar_len,
    output logic [MT_TAG_W-1:0]  ar_id,
    output logic                 busy,
    output logic                 done,
    output logic [MT_LEN_W-1:0]  drop_cnt
);

    mt_disp_state_t        state;
    logic [MT_ADDR_W-1:0]  addr;
    logic [MT_LEN_W-1:0]   remaining;
    logic [MT_TAG_W-1:0]   tag;

    logic [MT_LEN_W-1:0]   entry_len;
    logic [MT_BEATS_W-1:0] burst_beats;
    logic [MT_LEN_W-1:0]   burst_len;
    logic [MT_ADDR_W-1:0]  next_addr;
    logic [MT_LEN_W-1:0]   next_remaining;

    assign entry_len = info_in[MT_LEN_MSB:MT_LEN_LSB];

    // Pop is decoded combinationally so a drop can happen every IDLE cycle
    assign info_re = (state == IDLE) && !info_empty && !rst;

    mt_burst_calc #(
        .MAX_BURST  (MAX_BURST),
        .BEAT_BYTES (BEAT_BYTES)
    ) u_burst_calc (
        .remaining      (remaining),
        .addr           (addr),
        .beats          (burst_beats),
        .len            (burst_len),
        .next_addr      (next_addr),
        .next_remaining (next_remaining)
    );

    // addr/remaining always describe the burst not yet placed on the AR outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            addr      <= '0;
            remaining <= '0;
            tag       <= '0;
            ar_valid  <= 1'b0;
            ar_addr   <= '0;
            ar_len    <= '0;
            ar_id     <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            drop_cnt  <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (!info_empty) begin
                        if (entry_len == '0) begin
                            if (drop_cnt != '1) begin
                                drop_cnt <= drop_cnt + MT_LEN_W'(1);
                            end
                        end else begin
                            addr      <= {info_in[MT_ADDR_MSB:MT_ADDR_LSB], MT_ADDR_LSB'(0)};
                            remaining <= entry_len;
                            tag       <= info_in[MT_TAG_MSB:MT_TAG_LSB];
                            busy      <= 1'b1;
                            state     <= ISSUE;
                        end
                    end
                end
                ISSUE: begin
                    // Outputs only move when empty or handshaking, so they hold under backpressure
                    if (!ar_valid || ar_ready) begin
                        if (burst_beats == '0) begin
                            ar_valid <= 1'b0;
                            done     <= 1'b1;
                            busy     <= 1'b0;
                            state    <= IDLE;
                        end else begin
                            ar_valid  <= 1'b1;
                            ar_addr   <= addr;
                            ar_len    <= burst_len;
                            ar_id     <= tag;
                            addr      <= next_addr;
                            remaining <= next_remaining;
                        end
                    end
                end
            endcase
        end
    end

endmodule
